// File: rtl/if_stage_pkg.sv
// Pipeline-wide definitions shared by fetch, decode and the processor top.
// Widths, opcode constants, the NOP encoding and the fetch FSM encoding.
package if_stage_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 16;
   localparam int OP_WIDTH   = 4;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] instr_t;
   typedef logic [OP_WIDTH-1:0]   opcode_t;

   localparam opcode_t OP_NOP  = 4'h0;
   localparam opcode_t OP_ADD  = 4'h1;
   localparam opcode_t OP_LD   = 4'h8;
   localparam opcode_t OP_ST   = 4'h9;
   localparam opcode_t OP_BR   = 4'hC;
   localparam opcode_t OP_JMP  = 4'hD;
   localparam opcode_t HALT_OP = 4'hF;

   localparam instr_t NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;

   function automatic logic is_halt(input instr_t instr);
      return instr[DATA_WIDTH-1 -: OP_WIDTH] == HALT_OP;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side bus: instruction-memory read port plus the IF/ID register outputs.
// master = fetch stage, slave = instruction memory / decode side.
interface if_stage_if;
   import if_stage_pkg::*;

   addr_t  im_addr;
   logic   im_rd;
   instr_t im_r_data;
   instr_t ifid_instr;
   addr_t  ifid_pc;
   logic   ifid_valid;

   modport master (
      output im_addr, im_rd, ifid_instr, ifid_pc, ifid_valid,
      input  im_r_data
   );

   modport slave (
      input  im_addr, im_rd, ifid_instr, ifid_pc, ifid_valid,
      output im_r_data
   );
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: load captures a new instruction, squash inserts a bubble
// (and wins over load), neither holds. One-cycle latency; hold is the stall mechanism.
module if_stage_ifid_reg
   import if_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   squash,
   input  instr_t instr_in,
   input  addr_t  pc_in,
   output instr_t instr_q,
   output addr_t  pc_q,
   output logic   valid_q
);

   instr_t instr_d;
   addr_t  pc_d;
   logic   valid_d;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (squash) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = instr_in;
         pc_d    = pc_in;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, start/halt control, stall and redirect handling, IF/ID register.
// Fetch address appears in IF/ID one cycle later; stall freezes PC and IF/ID, redirect squashes.
module if_stage
   import if_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stall,
   input  logic          redirect,
   input  addr_t         redirect_pc,
   output logic          fetch_halted,
   if_stage_if.master    bus
);

   fetch_state_e state_q, state_d;
   addr_t        pc_q, pc_d;
   logic         ifid_load, ifid_squash;
   instr_t       ifid_instr;
   addr_t        ifid_pc;
   logic         ifid_valid;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ifid_load   = 1'b0;
      ifid_squash = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (start) begin
               state_d = FS_RUN;
               pc_d    = '0;
            end
         end
         FS_RUN: begin
            if (redirect) begin
               pc_d        = redirect_pc;
               ifid_squash = 1'b1;
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_d      = pc_q + addr_t'(1);
               if (is_halt(bus.im_r_data)) state_d = FS_HALTED;
            end
         end
         FS_HALTED: begin
            // A redirect means the HALT sat in a branch shadow: resume fetching.
            if (redirect) begin
               pc_d        = redirect_pc;
               ifid_squash = 1'b1;
               state_d     = FS_RUN;
            end else if (!stall) begin
               ifid_squash = 1'b1;
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   if_stage_ifid_reg u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (ifid_load),
      .squash   (ifid_squash),
      .instr_in (bus.im_r_data),
      .pc_in    (pc_q),
      .instr_q  (ifid_instr),
      .pc_q     (ifid_pc),
      .valid_q  (ifid_valid)
   );

   assign bus.im_addr    = pc_q;
   assign bus.im_rd      = (state_q == FS_RUN) && !stall;
   assign bus.ifid_instr = ifid_instr;
   assign bus.ifid_pc    = ifid_pc;
   assign bus.ifid_valid = ifid_valid;
   assign fetch_halted   = (state_q == FS_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus reset/IDLE sequences.
module tb_if_stage;
   import if_stage_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  start, stall, redirect;
   addr_t redirect_pc;
   logic  fetch_halted;

   if_stage_if bus ();

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .fetch_halted (fetch_halted),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   instr_t mem [256];
   // Junk on the read bus when not reading, so a wrongly captured word shows up.
   assign bus.im_r_data = bus.im_rd ? mem[bus.im_addr] : 16'hDEAD;

   typedef struct {
      logic   start;
      logic   stall;
      logic   redirect;
      addr_t  rpc;
      addr_t  exp_addr;
      logic   exp_rd;
      instr_t exp_instr;
      addr_t  exp_pc;
      logic   exp_valid;
      logic   exp_halted;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic sl, input logic rd_dir, input addr_t rpc,
                      input addr_t ea, input logic er, input instr_t ei, input addr_t ep,
                      input logic ev, input logic eh);
      vec_t v;
      v.start = st; v.stall = sl; v.redirect = rd_dir; v.rpc = rpc;
      v.exp_addr = ea; v.exp_rd = er; v.exp_instr = ei; v.exp_pc = ep;
      v.exp_valid = ev; v.exp_halted = eh;
      vecs.push_back(v);
   endtask

   task automatic check_regs(input string tag, input instr_t ei, input addr_t ep,
                             input logic ev, input logic eh);
      chk({tag, " ifid_instr"}, 32'(bus.ifid_instr), 32'(ei));
      chk({tag, " ifid_pc"}, 32'(bus.ifid_pc), 32'(ep));
      chk({tag, " ifid_valid"}, 32'(bus.ifid_valid), 32'(ev));
      chk({tag, " fetch_halted"}, 32'(fetch_halted), 32'(eh));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'h60, 8'(i)};
      mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003; mem[3] = 16'h4004;
      mem[4] = 16'h5005; mem[5] = 16'hF000; mem[8'h20] = 16'h8020;

      //  st sl rd rpc    addr   rd instr     pc     v  h
      add(1, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 0, 0);  // start from IDLE
      add(0, 0, 0, 8'h00, 8'h00, 1, 16'h1001, 8'h00, 1, 0);
      add(1, 0, 0, 8'h00, 8'h01, 1, 16'h2002, 8'h01, 1, 0);  // start in RUN ignored
      add(0, 0, 0, 8'h00, 8'h02, 1, 16'h3003, 8'h02, 1, 0);
      add(0, 1, 0, 8'h00, 8'h03, 0, 16'h3003, 8'h02, 1, 0);  // stall x2
      add(0, 1, 0, 8'h00, 8'h03, 0, 16'h3003, 8'h02, 1, 0);
      add(0, 0, 0, 8'h00, 8'h03, 1, 16'h4004, 8'h03, 1, 0);
      add(0, 1, 1, 8'h10, 8'h04, 0, 16'h0000, 8'h03, 0, 0);  // redirect beats stall
      add(0, 0, 0, 8'h00, 8'h10, 1, 16'h6010, 8'h10, 1, 0);
      add(0, 0, 1, 8'h04, 8'h11, 1, 16'h0000, 8'h10, 0, 0);
      add(0, 0, 0, 8'h00, 8'h04, 1, 16'h5005, 8'h04, 1, 0);
      add(0, 0, 0, 8'h00, 8'h05, 1, 16'hF000, 8'h05, 1, 1);  // HALT fetched
      add(1, 0, 0, 8'h00, 8'h06, 0, 16'h0000, 8'h05, 0, 1);  // bubbles, start ignored
      add(1, 0, 0, 8'h00, 8'h06, 0, 16'h0000, 8'h05, 0, 1);
      add(0, 0, 0, 8'h00, 8'h06, 0, 16'h0000, 8'h05, 0, 1);
      add(0, 0, 1, 8'h05, 8'h06, 0, 16'h0000, 8'h05, 0, 0);  // resume at HALT again
      add(0, 0, 0, 8'h00, 8'h05, 1, 16'hF000, 8'h05, 1, 1);
      add(0, 1, 0, 8'h00, 8'h06, 0, 16'hF000, 8'h05, 1, 1);  // stalled HALT held
      add(0, 1, 0, 8'h00, 8'h06, 0, 16'hF000, 8'h05, 1, 1);
      add(0, 0, 1, 8'h20, 8'h06, 0, 16'h0000, 8'h05, 0, 0);  // redirect out of HALTED
      add(0, 0, 0, 8'h00, 8'h20, 1, 16'h8020, 8'h20, 1, 0);
      add(0, 0, 1, 8'hFF, 8'h21, 1, 16'h0000, 8'h20, 0, 0);
      add(0, 0, 0, 8'h00, 8'hFF, 1, 16'h60FF, 8'hFF, 1, 0);  // PC wrap
      add(0, 0, 0, 8'h00, 8'h00, 1, 16'h1001, 8'h00, 1, 0);
      add(0, 0, 0, 8'h00, 8'h01, 1, 16'h2002, 8'h01, 1, 0);

      rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset im_rd", 32'(bus.im_rd), 32'd0);
      chk("reset im_addr", 32'(bus.im_addr), 32'd0);
      check_regs("reset", NOP_INSTR, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].start; stall = vecs[i].stall;
         redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
         #1;
         chk($sformatf("v%0d im_addr", i), 32'(bus.im_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("v%0d im_rd", i), 32'(bus.im_rd), 32'(vecs[i].exp_rd));
         @(posedge clk);
         #1;
         check_regs($sformatf("v%0d", i), vecs[i].exp_instr, vecs[i].exp_pc,
                    vecs[i].exp_valid, vecs[i].exp_halted);
      end

      // Reset mid-run, then IDLE must ignore stall/redirect until a new start.
      start = 1'b0; stall = 1'b0; redirect = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst im_rd", 32'(bus.im_rd), 32'd0);
      chk("midrst im_addr", 32'(bus.im_addr), 32'd0);
      check_regs("midrst", NOP_INSTR, 8'h00, 1'b0, 1'b0);

      redirect = 1'b1; redirect_pc = 8'h33; stall = 1'b1;
      @(posedge clk);
      #1;
      redirect = 1'b0; stall = 1'b0;
      #1;
      chk("idle im_addr", 32'(bus.im_addr), 32'd0);
      chk("idle im_rd", 32'(bus.im_rd), 32'd0);
      check_regs("idle", NOP_INSTR, 8'h00, 1'b0, 1'b0);

      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      chk("restart im_rd", 32'(bus.im_rd), 32'd1);
      chk("restart im_addr", 32'(bus.im_addr), 32'd0);
      @(posedge clk);
      #1;
      check_regs("restart", 16'h1001, 8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
